// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C register target:
//   i2c_state_e        - protocol state machine encoding
//   RW_WRITE / RW_READ - value of the R/W bit in the address byte
//   SLAVE_ADDR_DEFAULT - default 7-bit device address (write 8'h34, read 8'h35)
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h1A;

endpackage

// File: rtl/i2c_reg_slave_if.sv
// -----------------------------------------------------------------------------
// i2c_reg_slave_if
// Host-side register access port of the I2C register target.
//   oWR_EN    - one-cycle write strobe; oWR_ADDR/oWR_DATA are valid only while
//               it is high. There is no back-pressure: the host must accept
//               every strobe in the cycle it is presented.
//   oWR_ADDR  - register pointer for the write
//   oWR_DATA  - write data
//   oRD_ADDR  - current register pointer, always valid
//   iRD_DATA  - host read data for oRD_ADDR (combinational lookup is fine);
//               sampled by the target on the SCL falling edge that starts a
//               read byte
//   oBUSY     - high from an address match until STOP
//   o_I2C_END - one-cycle pulse on STOP after an addressed transfer
//   dbgState  - current protocol state, for observation only
// Modports: slave (the target), master (the host logic).
// -----------------------------------------------------------------------------
interface i2c_reg_slave_if;
    import i2c_pkg::*;

    logic       oWR_EN;
    logic [7:0] oWR_ADDR;
    logic [7:0] oWR_DATA;
    logic [7:0] oRD_ADDR;
    logic [7:0] iRD_DATA;
    logic       oBUSY;
    logic       o_I2C_END;
    i2c_state_e dbgState;

    modport slave (
        output oWR_EN, oWR_ADDR, oWR_DATA, oRD_ADDR, oBUSY, o_I2C_END, dbgState,
        input  iRD_DATA
    );

    modport master (
        input  oWR_EN, oWR_ADDR, oWR_DATA, oRD_ADDR, oBUSY, o_I2C_END, dbgState,
        output iRD_DATA
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync
// Synchronises SCL/SDA into the iCLK domain and detects bus events.
// Ports:
//   iCLK, iRST_N     - system clock, asynchronous active-low reset
//   iSCL, iSDA       - raw bus lines
//   scl_rise         - one-cycle pulse per SCL rising edge
//   scl_fall         - one-cycle pulse per SCL falling edge
//   start_det        - SDA fell while SCL high
//   stop_det         - SDA rose while SCL high
//   sda_s            - synchronised SDA, aligned with the event pulses
// The pipes reset to 1 (idle bus level) so that releasing reset on an idle
// bus cannot fabricate a START or STOP.
// -----------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iSCL,
    input  logic iSDA,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] sclPipe;
    logic [SYNC_STAGES-1:0] sdaPipe;

    // Edges come from the last two stages: "new" is one flop younger.
    logic sclNew, sclOld, sdaNew, sdaOld;
    assign sclNew = sclPipe[SYNC_STAGES-2];
    assign sclOld = sclPipe[SYNC_STAGES-1];
    assign sdaNew = sdaPipe[SYNC_STAGES-2];
    assign sdaOld = sdaPipe[SYNC_STAGES-1];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sclPipe   <= '1;
            sdaPipe   <= '1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_s     <= 1'b1;
        end else begin
            sclPipe   <= {sclPipe[SYNC_STAGES-2:0], iSCL};
            sdaPipe   <= {sdaPipe[SYNC_STAGES-2:0], iSDA};
            scl_rise  <= sclNew & ~sclOld;
            scl_fall  <= ~sclNew & sclOld;
            start_det <= sclNew & sclOld & ~sdaNew & sdaOld;
            stop_det  <= sclNew & sclOld & sdaNew & ~sdaOld;
            sda_s     <= sdaNew;
        end
    end

endmodule

// File: rtl/i2c_reg_slave.sv
// -----------------------------------------------------------------------------
// i2c_reg_slave
// I2C target for the three-byte write protocol (slave address, sub-address,
// data...) with sub-address then repeated-START reads.
// Parameters:
//   SLAVE_ADDR  - 7-bit device address
//   SYNC_STAGES - synchroniser depth on SCL/SDA (>= 2)
// Ports:
//   iCLK, iRST_N - system clock (>= 20x SCL), asynchronous active-low reset
//   I2C_SCLK     - bus clock from the master
//   I2C_SDAT     - open-drain bus data, driven only to 0
//   regBus       - host register port (see i2c_reg_slave_if)
// -----------------------------------------------------------------------------
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = SLAVE_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 3
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              I2C_SCLK,
    inout  wire               I2C_SDAT,
    i2c_reg_slave_if.slave    regBus
);

    logic sclRise, sclFall, startDet, stopDet, sdaS;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iSCL      (I2C_SCLK),
        .iSDA      (I2C_SDAT),
        .scl_rise  (sclRise),
        .scl_fall  (sclFall),
        .start_det (startDet),
        .stop_det  (stopDet),
        .sda_s     (sdaS)
    );

    i2c_state_e state;
    logic [2:0] bitCnt;
    logic [7:0] shiftReg;
    logic [7:0] ptr;
    logic       sdaLow;
    logic       readMode;   // address byte carried R/W = 1
    logic       rackAck;    // master ACKed a read byte; reload on next fall
    logic       wrEn;
    logic [7:0] wrAddr;
    logic [7:0] wrData;
    logic [7:0] rdAddr;
    logic       busy;
    logic       i2cEnd;

    logic [7:0] rxByte;
    assign rxByte = {shiftReg[6:0], sdaS};

    // In the *_ACK states sdaLow doubles as the phase flag: the first SCL
    // fall after bit 8 starts the ACK, the next one ends it.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= ST_IDLE;
            bitCnt   <= 3'd0;
            shiftReg <= 8'h00;
            ptr      <= 8'h00;
            sdaLow   <= 1'b0;
            readMode <= 1'b0;
            rackAck  <= 1'b0;
            wrEn     <= 1'b0;
            wrAddr   <= 8'h00;
            wrData   <= 8'h00;
            rdAddr   <= 8'h00;
            busy     <= 1'b0;
            i2cEnd   <= 1'b0;
        end else begin
            wrEn   <= 1'b0;
            i2cEnd <= 1'b0;
            rdAddr <= ptr;

            if (stopDet) begin
                state   <= ST_IDLE;
                sdaLow  <= 1'b0;
                bitCnt  <= 3'd0;
                rackAck <= 1'b0;
                i2cEnd  <= busy;
                busy    <= 1'b0;
            end else if (startDet) begin
                state   <= ST_ADDR;
                sdaLow  <= 1'b0;
                bitCnt  <= 3'd0;
                rackAck <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (sclRise) begin
                            shiftReg <= rxByte;
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                if (rxByte == {SLAVE_ADDR, RW_WRITE}) begin
                                    state    <= ST_ADDR_ACK;
                                    readMode <= 1'b0;
                                    busy     <= 1'b1;
                                end else if (rxByte == {SLAVE_ADDR, RW_READ}) begin
                                    state    <= ST_ADDR_ACK;
                                    readMode <= 1'b1;
                                    busy     <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (sclFall) begin
                            bitCnt <= 3'd0;
                            if (!sdaLow) begin
                                sdaLow <= 1'b1;
                            end else if (readMode) begin
                                // ACK ends and the first read bit starts on the same fall.
                                shiftReg <= regBus.iRD_DATA;
                                sdaLow   <= ~regBus.iRD_DATA[7];
                                state    <= ST_RDATA;
                            end else begin
                                sdaLow <= 1'b0;
                                state  <= ST_SUB;
                            end
                        end
                    end

                    ST_SUB: begin
                        if (sclRise) begin
                            shiftReg <= rxByte;
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                ptr   <= rxByte;
                                state <= ST_SUB_ACK;
                            end
                        end
                    end

                    ST_SUB_ACK: begin
                        if (sclFall) begin
                            bitCnt <= 3'd0;
                            if (!sdaLow) begin
                                sdaLow <= 1'b1;
                            end else begin
                                sdaLow <= 1'b0;
                                state  <= ST_WDATA;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (sclRise) begin
                            shiftReg <= rxByte;
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                state <= ST_WDATA_ACK;
                            end
                        end
                    end

                    ST_WDATA_ACK: begin
                        if (sclFall) begin
                            bitCnt <= 3'd0;
                            if (!sdaLow) begin
                                // Byte is committed only once it survived to this fall.
                                sdaLow <= 1'b1;
                                wrEn   <= 1'b1;
                                wrAddr <= ptr;
                                wrData <= shiftReg;
                                ptr    <= ptr + 8'd1;
                            end else begin
                                sdaLow <= 1'b0;
                                state  <= ST_WDATA;
                            end
                        end
                    end

                    ST_RDATA: begin
                        if (sclRise) begin
                            bitCnt <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                state <= ST_RACK;
                            end
                        end else if (sclFall) begin
                            shiftReg <= {shiftReg[6:0], 1'b1};
                            sdaLow   <= ~shiftReg[6];
                        end
                    end

                    ST_RACK: begin
                        if (sclRise) begin
                            if (!sdaS) begin
                                rackAck <= 1'b1;
                                ptr     <= ptr + 8'd1;
                            end else begin
                                sdaLow <= 1'b0;
                                state  <= ST_IGNORE;
                            end
                        end else if (sclFall) begin
                            if (rackAck) begin
                                // oRD_ADDR has had the whole SCL high phase to settle.
                                rackAck  <= 1'b0;
                                shiftReg <= regBus.iRD_DATA;
                                sdaLow   <= ~regBus.iRD_DATA[7];
                                bitCnt   <= 3'd0;
                                state    <= ST_RDATA;
                            end else begin
                                sdaLow <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        sdaLow <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

    assign regBus.oWR_EN    = wrEn;
    assign regBus.oWR_ADDR  = wrAddr;
    assign regBus.oWR_DATA  = wrData;
    assign regBus.oRD_ADDR  = rdAddr;
    assign regBus.oBUSY     = busy;
    assign regBus.o_I2C_END = i2cEnd;
    assign regBus.dbgState  = state;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_slave
// Directed bench for i2c_reg_slave: a bit-banged I2C master drives SCL/SDA,
// a small host model answers reads, and monitors track write strobes,
// STOP pulses and any SDA drive by the target.
// -----------------------------------------------------------------------------
module tb_i2c_reg_slave;
    import i2c_pkg::*;

    localparam int Q = 8;   // iCLK cycles per quarter SCL period

    logic clk;
    logic rstN;
    logic scl;
    logic mstLow;
    wire  sda;

    assign sda = mstLow ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_reg_slave_if regBus ();

    i2c_reg_slave #(.SLAVE_ADDR(7'h1A), .SYNC_STAGES(3)) dut (
        .iCLK     (clk),
        .iRST_N   (rstN),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda),
        .regBus   (regBus)
    );

    // Host register model for reads.
    always_comb begin
        case (regBus.oRD_ADDR)
            8'h10:   regBus.iRD_DATA = 8'hA5;
            8'h11:   regBus.iRD_DATA = 8'h5A;
            default: regBus.iRD_DATA = ~regBus.oRD_ADDR;
        endcase
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [15:0] expQ[$];     // expected {addr, data} writes
    logic [7:0]  rdExpQ[$];   // expected read bytes on SDA
    int cmpCnt  = 0;
    int errCnt  = 0;
    int wrCnt   = 0;
    int unexpWr = 0;
    int endCnt  = 0;
    logic dutLowSeen = 1'b0;
    logic busySeen   = 1'b0;
    logic prevEnd    = 1'b0;
    logic mstLowD    = 1'b0;
    logic lastSample;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rstN) begin
            if (regBus.oWR_EN) begin
                wrCnt++;
                if (expQ.size() > 0) begin
                    check("wr_addr_data", 32'({regBus.oWR_ADDR, regBus.oWR_DATA}), 32'(expQ.pop_front()));
                end else begin
                    unexpWr++;
                end
            end
            if (regBus.o_I2C_END) begin
                endCnt++;
                check("end_width", 32'(prevEnd), 0);
            end
            prevEnd = regBus.o_I2C_END;
            if (regBus.oBUSY) busySeen = 1'b1;
            // Only count a low line as target drive once the master has been off for a cycle.
            if (sda === 1'b0 && !mstLow && !mstLowD) dutLowSeen = 1'b1;
            mstLowD = mstLow;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic waitQ();
        repeat (Q) @(negedge clk);
    endtask

    // One SCL period: data set, SCL high, sample mid-high, SCL low.
    task automatic clockBit(input logic b);
        mstLow = ~b;
        waitQ();
        scl = 1'b1;
        waitQ();
        lastSample = sda;
        waitQ();
        scl = 1'b0;
        waitQ();
    endtask

    task automatic i2cStart();
        mstLow = 1'b0;
        waitQ();
        scl = 1'b1;
        waitQ();
        mstLow = 1'b1;
        waitQ();
        scl = 1'b0;
        waitQ();
    endtask

    task automatic i2cStop();
        mstLow = 1'b1;
        waitQ();
        scl = 1'b1;
        waitQ();
        mstLow = 1'b0;
        waitQ();
        waitQ();
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) clockBit(b[i]);
        clockBit(1'b1);
        ack = lastSample;
    endtask

    task automatic readByte(input logic masterAck, output logic [7:0] data);
        logic [7:0] d;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clockBit(1'b1);
            d[i] = lastSample;
        end
        clockBit(~masterAck);
        data = d;
    endtask

    task automatic clearFlags();
        wrCnt = 0;
        unexpWr = 0;
        endCnt = 0;
        dutLowSeen = 1'b0;
        busySeen = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic       ack;
        logic [7:0] rd;

        rstN   = 1'b0;
        scl    = 1'b1;
        mstLow = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_wr_en",   32'(regBus.oWR_EN), 0);
        check("rst_busy",    32'(regBus.oBUSY), 0);
        check("rst_end",     32'(regBus.o_I2C_END), 0);
        check("rst_rd_addr", 32'(regBus.oRD_ADDR), 0);
        check("rst_sda",     32'(sda), 1);
        check("rst_state",   32'(regBus.dbgState), 32'(ST_IDLE));
        rstN = 1'b1;
        repeat (4) waitQ();

        // 1: single write 34/0E/01
        clearFlags();
        i2cStart();
        sendByte(8'h34, ack);  check("w1_addr_ack", 32'(ack), 0);
        check("w1_busy", 32'(regBus.oBUSY), 1);
        sendByte(8'h0E, ack);  check("w1_sub_ack", 32'(ack), 0);
        expQ.push_back({8'h0E, 8'h01});
        sendByte(8'h01, ack);  check("w1_data_ack", 32'(ack), 0);
        i2cStop();
        repeat (2) waitQ();
        check("w1_wr_cnt",  32'(wrCnt), 1);
        check("w1_unexp",   32'(unexpWr), 0);
        check("w1_end_cnt", 32'(endCnt), 1);
        check("w1_busy_end", 32'(regBus.oBUSY), 0);
        check("w1_rd_addr", 32'(regBus.oRD_ADDR), 32'h0F);
        check("w1_exp_left", 32'(expQ.size()), 0);

        // 2: foreign address 8'h40
        clearFlags();
        i2cStart();
        sendByte(8'h40, ack);  check("ig_addr_nack", 32'(ack), 1);
        check("ig_state", 32'(regBus.dbgState), 32'(ST_IGNORE));
        sendByte(8'h0E, ack);  check("ig_b1_nack", 32'(ack), 1);
        sendByte(8'h77, ack);  check("ig_b2_nack", 32'(ack), 1);
        i2cStop();
        repeat (2) waitQ();
        check("ig_sda_driven", 32'(dutLowSeen), 0);
        check("ig_wr_cnt",     32'(wrCnt), 0);
        check("ig_end_cnt",    32'(endCnt), 0);
        check("ig_busy_seen",  32'(busySeen), 0);

        // 3: burst with pointer wrap
        clearFlags();
        i2cStart();
        sendByte(8'h34, ack);  check("b_addr_ack", 32'(ack), 0);
        sendByte(8'hFF, ack);  check("b_sub_ack", 32'(ack), 0);
        expQ.push_back({8'hFF, 8'hAA});
        sendByte(8'hAA, ack);  check("b_d0_ack", 32'(ack), 0);
        expQ.push_back({8'h00, 8'h55});
        sendByte(8'h55, ack);  check("b_d1_ack", 32'(ack), 0);
        i2cStop();
        repeat (2) waitQ();
        check("b_wr_cnt",   32'(wrCnt), 2);
        check("b_unexp",    32'(unexpWr), 0);
        check("b_rd_addr",  32'(regBus.oRD_ADDR), 32'h01);
        check("b_end_cnt",  32'(endCnt), 1);

        // 4: sub-address, repeated START, read two bytes
        clearFlags();
        i2cStart();
        sendByte(8'h34, ack);  check("r_waddr_ack", 32'(ack), 0);
        sendByte(8'h10, ack);  check("r_sub_ack", 32'(ack), 0);
        i2cStart();
        sendByte(8'h35, ack);  check("r_raddr_ack", 32'(ack), 0);
        rdExpQ.push_back(8'hA5);
        rdExpQ.push_back(8'h5A);
        readByte(1'b1, rd);    check("r_byte0", 32'(rd), 32'(rdExpQ.pop_front()));
        readByte(1'b0, rd);    check("r_byte1", 32'(rd), 32'(rdExpQ.pop_front()));
        check("r_state_nack", 32'(regBus.dbgState), 32'(ST_IGNORE));
        i2cStop();
        repeat (2) waitQ();
        check("r_rd_addr", 32'(regBus.oRD_ADDR), 32'h11);
        check("r_wr_cnt",  32'(wrCnt), 0);
        check("r_end_cnt", 32'(endCnt), 1);

        // 5: STOP after 4 data bits, then a normal write
        clearFlags();
        i2cStart();
        sendByte(8'h34, ack);  check("a_addr_ack", 32'(ack), 0);
        sendByte(8'h20, ack);  check("a_sub_ack", 32'(ack), 0);
        for (int i = 0; i < 4; i++) clockBit(1'($urandom_range(0, 1)));
        i2cStop();
        repeat (2) waitQ();
        check("a_wr_cnt",  32'(wrCnt), 0);
        check("a_rd_addr", 32'(regBus.oRD_ADDR), 32'h20);
        clearFlags();
        i2cStart();
        sendByte(8'h34, ack);  check("a2_addr_ack", 32'(ack), 0);
        sendByte(8'h30, ack);  check("a2_sub_ack", 32'(ack), 0);
        expQ.push_back({8'h30, 8'h77});
        sendByte(8'h77, ack);  check("a2_data_ack", 32'(ack), 0);
        i2cStop();
        repeat (2) waitQ();
        check("a2_wr_cnt",  32'(wrCnt), 1);
        check("a2_rd_addr", 32'(regBus.oRD_ADDR), 32'h31);

        // 6: reset while the target drives the address ACK
        clearFlags();
        i2cStart();
        for (int i = 7; i >= 0; i--) clockBit(1'(8'h34 >> i));
        mstLow = 1'b0;
        waitQ();
        check("x_ack_driven", 32'(sda), 0);
        rstN = 1'b0;
        #1;
        check("x_sda_released", 32'(sda), 1);
        check("x_wr_en",   32'(regBus.oWR_EN), 0);
        check("x_wr_addr", 32'(regBus.oWR_ADDR), 0);
        check("x_wr_data", 32'(regBus.oWR_DATA), 0);
        check("x_rd_addr", 32'(regBus.oRD_ADDR), 0);
        check("x_busy",    32'(regBus.oBUSY), 0);
        check("x_end",     32'(regBus.o_I2C_END), 0);
        repeat (4) @(negedge clk);
        rstN = 1'b1;
        waitQ();
        clearFlags();
        clockBit(1'b1);
        sendByte(8'h34, ack);  check("x_ignored_ack", 32'(ack), 1);
        i2cStop();
        repeat (2) waitQ();
        check("x_sda_driven", 32'(dutLowSeen), 0);
        check("x_wr_cnt",     32'(wrCnt), 0);
        check("x_end_cnt",    32'(endCnt), 0);
        clearFlags();
        i2cStart();
        sendByte(8'h34, ack);  check("x2_addr_ack", 32'(ack), 0);
        sendByte(8'h42, ack);  check("x2_sub_ack", 32'(ack), 0);
        expQ.push_back({8'h42, 8'h99});
        sendByte(8'h99, ack);  check("x2_data_ack", 32'(ack), 0);
        i2cStop();
        repeat (2) waitQ();
        check("x2_wr_cnt",   32'(wrCnt), 1);
        check("x2_end_cnt",  32'(endCnt), 1);
        check("x2_exp_left", 32'(expQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
